// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - GRF write scoreboard with hazard stall; optional stall statistic under SCOREBOARD_STATS_EN
module reg_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dst,
  input  logic [1:0]  issue_tnew,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [1:0]  rs_tuse,
  input  logic [1:0]  rt_tuse,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  output logic        stall,
  output logic        err,
  output logic [31:0] stall_cnt
);

  // Entry 0 is carried for uniform indexing but never leaves its reset value.
  logic [1:0] cnt_q  [32];
  logic [1:0] cnt_d  [32];
  logic [1:0] tnew_q [32];
  logic [1:0] tnew_d [32];
  logic       err_q;
  logic       err_d;
  logic       blk_rs;
  logic       blk_rt;
  logic       iss_ok;

  // Hazard check on pre-edge state; a single in-flight writer retiring this
  // cycle is covered by the register file's write-through.
  always_comb begin
    blk_rs = (rs_addr != 5'd0) && (cnt_q[rs_addr] != 2'd0) &&
             (tnew_q[rs_addr] > rs_tuse) &&
             !(wb_we && (wb_addr == rs_addr) && (cnt_q[rs_addr] == 2'd1));
    blk_rt = (rt_addr != 5'd0) && (cnt_q[rt_addr] != 2'd0) &&
             (tnew_q[rt_addr] > rt_tuse) &&
             !(wb_we && (wb_addr == rt_addr) && (cnt_q[rt_addr] == 2'd1));
    stall  = blk_rs | blk_rt;
    iss_ok = issue_valid && !stall && (issue_dst != 5'd0);
  end

  // Per-register bookkeeping: count writers in flight, age the youngest
  // writer's latency, flag over/underflow of the writer count.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < 32; r++) begin
      logic       hit_iss;
      logic       hit_wb;
      logic [1:0] tdec;
      hit_iss   = iss_ok && (issue_dst == 5'(r));
      hit_wb    = wb_we && (wb_addr == 5'(r)) && (r != 0);
      tdec      = (tnew_q[r] != 2'd0) ? tnew_q[r] - 2'd1 : 2'd0;
      cnt_d[r]  = cnt_q[r];
      tnew_d[r] = tdec;
      if (hit_iss && hit_wb) begin
        // One writer retires as another enters: count is unchanged.
        if (cnt_q[r] == 2'd0) begin
          err_d = 1'b1;
        end
        tnew_d[r] = issue_tnew;
      end else if (hit_iss) begin
        if (cnt_q[r] == 2'd3) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + 2'd1;
        end
        tnew_d[r] = issue_tnew;
      end else if (hit_wb) begin
        if (cnt_q[r] == 2'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - 2'd1;
        end
      end
      // No writer left means nothing to wait for.
      if (cnt_d[r] == 2'd0) begin
        tnew_d[r] = 2'd0;
      end
    end
  end

  // State register; reset wins over any same-cycle issue or writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r]  <= 2'd0;
        tnew_q[r] <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r]  <= cnt_d[r];
        tnew_q[r] <= tnew_d[r];
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count cycles in which a requested issue was held back; wraps naturally.
  always_comb begin
    stall_cnt_d = stall_cnt_q + ((issue_valid && stall) ? 32'd1 : 32'd0);
  end

  // Statistic register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule
